step_controller: RTL and testbench
==================================

STEP_CONTROLLER -- requirements
Module: step_controller

Interface
REQ-001 The parameter DEBOUNCE_CYCLES SHALL default to 1000000 and set the button stability window (20 ms at 50 MHz).
REQ-002 The parameter CNT_W SHALL default to 16 and set the width of step_count.
REQ-003 Port clk SHALL be an input, 1 bit wide, and be the single clock; all logic is on its rising edge.
REQ-004 Port reset SHALL be an input, 1 bit wide, asynchronous and active-low.
REQ-005 Port slow_clk SHALL be an input, 1 bit wide, carrying the clk-domain divided clock; only its rising edges are used.
REQ-006 Port btn_step SHALL be an input, 1 bit wide, the raw asynchronous manual-step pushbutton, active-high.
REQ-007 Port sw_run SHALL be an input, 1 bit wide, the raw asynchronous mode switch: 1 selects free-run, 0 selects single-step.
REQ-008 Port halt_req SHALL be an input, 1 bit wide, a clk-synchronous processor halt request, level-sensitive.
REQ-009 Port cpu_en SHALL be an output, 1 bit wide, a registered one-cycle processor clock-enable pulse.
REQ-010 Port state SHALL be an output, 2 bits wide, giving the current FSM state encoding.
REQ-011 Port step_count SHALL be an output, CNT_W bits wide, counting the cpu_en pulses issued since reset.

Function
REQ-012 btn_step and sw_run SHALL each pass through a 2-flop synchronizer before any use.
REQ-013 The debounced button level SHALL change only after the synchronized btn_step has differed from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count from 0.
REQ-014 A press event SHALL be a single-cycle pulse on a debounced 0->1 transition; a 1->0 transition SHALL produce no event.
REQ-015 A slow_clk rising edge SHALL be detected as slow_clk=1 with the previous-cycle sample=0, giving a one-cycle tick.
REQ-016 The FSM SHALL have three states: RUN=2'b01, PAUSE=2'b00, HALTED=2'b10; 2'b11 is illegal and SHALL go to PAUSE.
REQ-017 In RUN, cpu_en SHALL assert in the cycle after each tick, and press events SHALL be discarded, not queued.
REQ-018 In PAUSE, cpu_en SHALL assert in the cycle after each press event, and ticks SHALL be ignored.
REQ-019 The transition RUN->PAUSE SHALL occur when the synchronized sw_run=0, and PAUSE->RUN when it is 1, both evaluated every cycle.
REQ-020 The transition from RUN or PAUSE to HALTED SHALL occur when halt_req=1; HALTED is left only by reset, and cpu_en stays 0 in HALTED.
REQ-021 If halt_req=1 in the same cycle as a tick or press event, the halt SHALL win and no cpu_en pulse SHALL be issued.
REQ-022 If a mode change and an event coincide, the event SHALL be judged against the state before the transition.
REQ-023 cpu_en SHALL never be high for two consecutive cycles.
REQ-024 step_count SHALL increment by 1 in the cycle cpu_en is high and saturate at all-ones without wrapping.

Reset
REQ-025 While reset=0, the design SHALL immediately hold cpu_en=0, state=PAUSE, step_count=0, synchronizers=0, the debounced level=0, the debounce counter=0, and the slow_clk sample=0.
REQ-026 Reset asserted mid-operation SHALL abort any debounce in progress; after release, the first cpu_en requires a fresh tick or press event.

Structure
REQ-027 The state encodings and the default DEBOUNCE_CYCLES SHALL reside in the shared package step_pkg.
REQ-028 Synchronizer, debounce counter and edge detect SHALL form the sub-module btn_debounce, with ports clk, reset, din, and press; the counter is sized as $clog2(DEBOUNCE_CYCLES+1).

Verification (DEBOUNCE_CYCLES=4)
REQ-029 The bench SHALL check: sw_run=1 held, slow_clk toggled every 10 cycles for 3 rising edges -> exactly 3 cpu_en pulses, each one cycle after a tick, and step_count=3.
REQ-030 The bench SHALL check: sw_run=0, btn_step bouncing 1/0/1 at 2-cycle spacing then held high for 10 cycles -> exactly 1 cpu_en pulse and no pulses from ticks.
REQ-031 The bench SHALL check: halt_req=1 in the same cycle as a tick -> state=HALTED, cpu_en stays 0, and later ticks and presses are ignored until reset.
REQ-032 The bench SHALL check: step_count preset near saturation via CNT_W=2 and 5 ticks in RUN -> step_count=3 and held.
REQ-033 The bench SHALL check: reset=0 asserted during a debounce in PAUSE, then released -> all outputs return to reset values and no cpu_en pulse occurs without a new press.

Source files
------------

// File: rtl/step_pkg.sv
// Shared definitions for the step controller: FSM encodings, default
// parameter values and the event-acceptance rule used by the FSM.
package step_pkg;

    typedef enum logic [1:0] {
        ST_PAUSE  = 2'b00,
        ST_RUN    = 2'b01,
        ST_HALTED = 2'b10
    } step_state_e;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;
    localparam int CNT_W_DEFAULT           = 16;

    // An event fires a step only if it belongs to the current mode and no
    // halt is requested in the same cycle.
    function automatic logic event_accepted(
        input step_state_e st,
        input logic        tick,
        input logic        press,
        input logic        halt
    );
        logic acc;
        case (st)
            ST_RUN:   acc = tick & ~halt;
            ST_PAUSE: acc = press & ~halt;
            default:  acc = 1'b0;
        endcase
        return acc;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, stability-window debounce and
// a single-cycle pulse on each debounced press (release produces nothing).
module btn_debounce
    import step_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic press
);

    localparam int            CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_r;
    logic          sync2_r;
    logic          level_r;
    logic          press_r;
    logic [CW-1:0] cnt_r;
    logic          differ_s;
    logic          settle_s;

    // The window closes on the DEBOUNCE_CYCLES-th consecutive differing cycle.
    always_comb begin
        differ_s = sync2_r ^ level_r;
        settle_s = differ_s && (cnt_r == LAST);
    end

    // Synchronizer, stability counter, debounced level and press pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            level_r <= 1'b0;
            cnt_r   <= '0;
            press_r <= 1'b0;
        end else begin
            sync1_r <= din;
            sync2_r <= sync1_r;
            if (settle_s) begin
                level_r <= sync2_r;
                cnt_r   <= '0;
            end else if (differ_s) begin
                cnt_r   <= cnt_r + CW'(1);
            end else begin
                cnt_r   <= '0;
            end
            press_r <= settle_s & sync2_r;
        end
    end

    assign press = press_r;

endmodule

// File: rtl/step_controller.sv
// Processor clock-enable generator: free-run on slow_clk ticks, single-step
// on debounced button presses, and a sticky halt that only reset clears.
module step_controller
    import step_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             slow_clk,
    input  logic             btn_step,
    input  logic             sw_run,
    input  logic             halt_req,
    output logic             cpu_en,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] step_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             run_sync1_r;
    logic             run_sync2_r;
    logic             slow_prev_r;
    logic             tick_s;
    logic             press_s;
    step_state_e      state_r;
    step_state_e      state_next_s;
    logic             fire_s;
    logic             cpu_en_r;
    logic [CNT_W-1:0] count_r;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn (
        .clk   (clk),
        .reset (reset),
        .din   (btn_step),
        .press (press_s)
    );

    assign tick_s = slow_clk & ~slow_prev_r;

    // Mode-switch synchronizer and slow_clk edge-detect history.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_sync1_r <= 1'b0;
            run_sync2_r <= 1'b0;
            slow_prev_r <= 1'b0;
        end else begin
            run_sync1_r <= sw_run;
            run_sync2_r <= run_sync1_r;
            slow_prev_r <= slow_clk;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_PAUSE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic; halt has priority over mode changes.
    always_comb begin
        state_next_s = ST_PAUSE;
        case (state_r)
            ST_RUN: begin
                if (halt_req) begin
                    state_next_s = ST_HALTED;
                end else if (!run_sync2_r) begin
                    state_next_s = ST_PAUSE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_PAUSE: begin
                if (halt_req) begin
                    state_next_s = ST_HALTED;
                end else if (run_sync2_r) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_PAUSE;
                end
            end
            ST_HALTED: state_next_s = ST_HALTED;
            default:   state_next_s = ST_PAUSE;
        endcase
    end

    // FSM output logic: events are judged against the pre-transition state,
    // and a pulse is never issued right after another.
    always_comb begin
        fire_s = 1'b0;
        if (!cpu_en_r) begin
            fire_s = event_accepted(state_r, tick_s, press_s, halt_req);
        end else begin
            fire_s = 1'b0;
        end
    end

    // Registered enable pulse and saturating step counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_en_r <= 1'b0;
            count_r  <= '0;
        end else begin
            cpu_en_r <= fire_s;
            if (cpu_en_r && (count_r != CNT_MAX)) begin
                count_r <= count_r + CNT_W'(1);
            end else begin
                count_r <= count_r;
            end
        end
    end

    assign cpu_en     = cpu_en_r;
    assign state      = state_r;
    assign step_count = count_r;

endmodule

// File: tb/tb_step_controller.sv
// Directed bench for step_controller with a 4-cycle debounce window; a second
// instance with a 2-bit counter shares the inputs to exercise saturation.
module tb_step_controller;

    logic        clk;
    logic        reset;
    logic        slow_clk;
    logic        btn_step;
    logic        sw_run;
    logic        halt_req;
    logic        cpu_en;
    logic [1:0]  state;
    logic [15:0] step_count;
    logic        sat_cpu_en;
    logic [1:0]  sat_state;
    logic [1:0]  sat_count;

    int checks = 0;
    int fails  = 0;
    int pulses = 0;
    int dbl    = 0;
    logic prev_en = 1'b0;
    logic tick_gen = 1'b0;
    int   phase = 0;

    step_controller #(.DEBOUNCE_CYCLES(4), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .slow_clk(slow_clk), .btn_step(btn_step),
        .sw_run(sw_run), .halt_req(halt_req), .cpu_en(cpu_en),
        .state(state), .step_count(step_count)
    );

    step_controller #(.DEBOUNCE_CYCLES(4), .CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .slow_clk(slow_clk), .btn_step(btn_step),
        .sw_run(sw_run), .halt_req(halt_req), .cpu_en(sat_cpu_en),
        .state(sat_state), .step_count(sat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse monitor sampled mid-cycle.
    always @(negedge clk) begin
        if (cpu_en) pulses = pulses + 1;
        if (cpu_en && prev_en) dbl = dbl + 1;
        prev_en = cpu_en;
    end

    typedef struct {
        logic       slow;
        logic       run;
        logic       btn;
        logic       halt;
        int         n;
        logic       en_first;
        logic [1:0] st;
        int         cnt;
        int         sat;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            if (tick_gen) begin
                phase = phase + 1;
                if (phase % 3 == 0) slow_clk = ~slow_clk;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    int p0, p1, p2;
    logic rest_bad;

    initial begin
        // slow run  btn   halt  n   en1   state  cnt sat
        tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3,  1'b0, 2'b01, 0, 0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 10, 1'b1, 2'b01, 1, 1};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 10, 1'b0, 2'b01, 1, 1};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 10, 1'b1, 2'b01, 2, 2};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 10, 1'b0, 2'b01, 2, 2};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 10, 1'b1, 2'b01, 3, 3};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 10, 1'b0, 2'b01, 3, 3};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 10, 1'b1, 2'b01, 4, 3};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 10, 1'b0, 2'b01, 4, 3};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 10, 1'b1, 2'b01, 5, 3};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 10, 1'b0, 2'b01, 5, 3};

        reset = 1'b0; slow_clk = 1'b0; btn_step = 1'b0; sw_run = 1'b0; halt_req = 1'b0;
        cyc(3);
        chk("rst_en",    {31'd0, cpu_en}, 32'd0);
        chk("rst_state", {30'd0, state}, 32'd0);
        chk("rst_count", {16'd0, step_count}, 32'd0);
        reset = 1'b1;

        // Free-run ticks, then two more to push the 2-bit counter into saturation
        for (int r = 0; r < 11; r++) begin
            slow_clk = tbl[r].slow; sw_run = tbl[r].run;
            btn_step = tbl[r].btn;  halt_req = tbl[r].halt;
            rest_bad = 1'b0;
            for (int k = 0; k < tbl[r].n; k++) begin
                @(posedge clk);
                #1;
                if (k == 0) chk($sformatf("v%0d_en_first", r), {31'd0, cpu_en}, {31'd0, tbl[r].en_first});
                else if (cpu_en) rest_bad = 1'b1;
            end
            chk($sformatf("v%0d_en_rest", r), {31'd0, rest_bad}, 32'd0);
            chk($sformatf("v%0d_state", r), {30'd0, state}, {30'd0, tbl[r].st});
            chk($sformatf("v%0d_count", r), {16'd0, step_count}, tbl[r].cnt);
            chk($sformatf("v%0d_sat", r), {30'd0, sat_count}, tbl[r].sat);
        end
        settle();
        chk("run_pulses", pulses, 32'd5);

        // Single-step: bouncing press gives exactly one pulse, ticks ignored
        sw_run = 1'b0;
        cyc(3);
        chk("to_pause", {30'd0, state}, 32'd0);
        settle();
        p0 = pulses;
        tick_gen = 1'b1;
        btn_step = 1'b1; cyc(2);
        btn_step = 1'b0; cyc(2);
        btn_step = 1'b1; cyc(10);
        settle();
        chk("press_once", pulses - p0, 32'd1);
        btn_step = 1'b0; cyc(10);
        settle();
        chk("no_release_evt", pulses - p0, 32'd1);
        chk("pause_count", {16'd0, step_count}, 32'd6);

        // Halt coinciding with a tick wins, and HALTED is sticky
        tick_gen = 1'b0; slow_clk = 1'b0; sw_run = 1'b1;
        cyc(3);
        chk("to_run", {30'd0, state}, 32'd1);
        settle();
        p1 = pulses;
        slow_clk = 1'b1; halt_req = 1'b1;
        cyc(1);
        chk("halt_state", {30'd0, state}, 32'd2);
        chk("halt_no_en", {31'd0, cpu_en}, 32'd0);
        halt_req = 1'b0; tick_gen = 1'b1;
        btn_step = 1'b1; cyc(10);
        btn_step = 1'b0; sw_run = 1'b0; cyc(10);
        settle();
        chk("halt_pulses", pulses - p1, 32'd0);
        chk("halt_sticky", {30'd0, state}, 32'd2);
        chk("halt_count", {16'd0, step_count}, 32'd6);

        // Reset clears HALTED; reset mid-debounce aborts the press
        tick_gen = 1'b0; slow_clk = 1'b0; reset = 1'b0;
        cyc(2);
        chk("rst2_state", {30'd0, state}, 32'd0);
        chk("rst2_count", {16'd0, step_count}, 32'd0);
        chk("rst2_sat",   {30'd0, sat_count}, 32'd0);
        reset = 1'b1;
        cyc(3);
        btn_step = 1'b1; cyc(10);
        chk("step_after_rst", {16'd0, step_count}, 32'd1);
        btn_step = 1'b0; cyc(10);
        btn_step = 1'b1; cyc(4);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_count", {16'd0, step_count}, 32'd0);
        chk("async_rst_state", {30'd0, state}, 32'd0);
        chk("async_rst_en",    {31'd0, cpu_en}, 32'd0);
        btn_step = 1'b0;
        cyc(3);
        reset = 1'b1;
        settle();
        p2 = pulses;
        cyc(15);
        settle();
        chk("no_stale_press", pulses - p2, 32'd0);
        chk("no_stale_count", {16'd0, step_count}, 32'd0);
        btn_step = 1'b1; cyc(10);
        settle();
        chk("fresh_press", pulses - p2, 32'd1);
        chk("fresh_count", {16'd0, step_count}, 32'd1);
        chk("no_double_en", dbl, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
